// File: rtl/ex_hazard_ctrl.sv
// Execute-stage sequencing controller.
// Produces the stall/flush controls around EX for load-use hazards, taken
// branches, traps and multi-cycle coprocessor operations. A coprocessor op
// is started with a one-cycle copStart, then EX is held until copDone, a
// trap, or the timeout fires (copAbort). A saturating counter accumulates
// every cycle in which the PC is held.
module ex_hazard_ctrl #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs1,
  input  logic [4:0]       idRs2,
  input  logic             idUsesRs1,
  input  logic             idUsesRs2,
  input  logic [4:0]       exRd,
  input  logic             exMemRead,
  input  logic             exMultiCycle,
  input  logic             branchTakenIn,
  input  logic             trapIn,
  input  logic             copDone,
  output logic             copStart,
  output logic             copAbort,
  output logic             copTimeout,
  output logic             pcStall,
  output logic             ifIdStall,
  output logic             exHold,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             exMemFlush,
  output logic             busy,
  output logic [CNT_W-1:0] stallCnt
);

  typedef enum logic {
    IDLE     = 1'b0,
    COP_WAIT = 1'b1
  } state_t;

  // Counter value on the last permitted wait cycle.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  state_t               stateNxt;
  logic [TIMEOUT_W-1:0] toCnt;
  logic [TIMEOUT_W-1:0] toCntNxt;
  logic                 loadUse;
  logic                 copStartCond;
  logic                 toLast;
  logic                 timeoutFire;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A load in EX whose destination is read by the instruction in ID; x0 never
  // creates a dependency.
  assign loadUse = exMemRead && (exRd != 5'd0) &&
                   ((idUsesRs1 && (idRs1 == exRd)) ||
                    (idUsesRs2 && (idRs2 == exRd)));

  // Traps and taken branches kill the multi-cycle op before it is launched.
  assign copStartCond = (state == IDLE) && exMultiCycle && !trapIn && !branchTakenIn;

  assign toLast = (toCnt == TO_LAST);
  assign busy   = (state == COP_WAIT);

  // State and timeout counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      state <= stateNxt;
      toCnt <= toCntNxt;
    end
  end

  // Next-state and timeout counter update.
  always_comb begin
    stateNxt = state;
    toCntNxt = toCnt;
    unique case (state)
      IDLE: begin
        if (copStartCond) begin
          stateNxt = COP_WAIT;
          toCntNxt = '0;
        end
      end
      COP_WAIT: begin
        if (trapIn || copDone || toLast) begin
          stateNxt = IDLE;
        end else begin
          toCntNxt = toCnt + TIMEOUT_W'(1);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Stall/flush/handshake outputs, decoded by priority trap > branch > multi-cycle > load-use.
  always_comb begin
    copStart    = 1'b0;
    copAbort    = 1'b0;
    pcStall     = 1'b0;
    ifIdStall   = 1'b0;
    exHold      = 1'b0;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    exMemFlush  = 1'b0;
    timeoutFire = 1'b0;
    unique case (state)
      IDLE: begin
        if (trapIn) begin
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
          exMemFlush = 1'b1;
        end else if (branchTakenIn) begin
          ifIdFlush = 1'b1;
          idExFlush = 1'b1;
        end else if (exMultiCycle) begin
          copStart   = 1'b1;
          pcStall    = 1'b1;
          ifIdStall  = 1'b1;
          exHold     = 1'b1;
          exMemFlush = 1'b1;
        end else if (loadUse) begin
          pcStall   = 1'b1;
          ifIdStall = 1'b1;
          idExFlush = 1'b1;
        end
      end
      COP_WAIT: begin
        if (trapIn) begin
          copAbort   = 1'b1;
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
          exMemFlush = 1'b1;
        end else if (copDone) begin
          // Everything released so the coprocessor result flows into MEM.
        end else if (toLast) begin
          copAbort    = 1'b1;
          ifIdFlush   = 1'b1;
          idExFlush   = 1'b1;
          exMemFlush  = 1'b1;
          timeoutFire = 1'b1;
        end else begin
          pcStall    = 1'b1;
          ifIdStall  = 1'b1;
          exHold     = 1'b1;
          exMemFlush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Timeout error pulse, one cycle after the abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      copTimeout <= 1'b0;
    end else begin
      copTimeout <= timeoutFire;
    end
  end

  // Saturating stalled-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCnt <= '0;
    end else if (pcStall) begin
      stallCnt <= sat_inc(stallCnt);
    end
  end

endmodule
